sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 152 +++++++++++++++
 tb/tb_sram_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: byte-wide SRAM slave with a fixed wait-state handshake toward a memory controller.
// Ports: clk/rst (sync, active-high), mem_cs/mem_read/mem_write/mem_addr/mem_wdata in; mem_ready/mem_rdata/wp_violation out.
// Optional write protection above ROM_BASE is enabled by defining SRAM_RESPONDER_WP_EN.
module sram_responder #(
  parameter int          WAIT_STATES = 2,
  parameter int          ADDR_BITS   = 12,
  parameter logic [15:0] ROM_BASE    = 16'hF100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_cs,
  output logic        mem_ready,
  output logic        wp_violation
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Last WAIT count before moving to READY; unused when WAIT_STATES == 0.
  localparam logic [2:0] CNT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

`ifdef SRAM_RESPONDER_WP_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY, S_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        op_wr_q, op_wr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        wp_q, wp_d;
  logic        mem_we;
  logic        req;
  logic        wp_hit;
  logic [ADDR_BITS-1:0] idx;

  logic [7:0] mem [DEPTH];

  // A request needs exactly one strobe; both or neither is ignored.
  assign req    = mem_cs & (mem_read ^ mem_write);
  assign idx    = addr_q[ADDR_BITS-1:0];
  assign wp_hit = WP_EN & (addr_q >= ROM_BASE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      op_wr_q <= 1'b0;
      rdata_q <= 8'h00;
      ready_q <= 1'b0;
      wp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      wp_q    <= wp_d;
    end
  end

  // Array write is gated by rst so a reset in READY drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  // Next-state and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          op_wr_d = mem_write;
          cnt_d   = 3'd0;
          state_d = (WAIT_STATES == 0) ? S_READY : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_cs) begin
          // Abort: nothing is committed and no handshake is produced.
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_READY;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_READY: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold here until cs drops so one cs assertion yields one access.
        if (!mem_cs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: ready/rdata/wp are registered on the edge that leaves READY,
  // so they appear WAIT_STATES+1 cycles after the sampling edge.
  always_comb begin
    ready_d = 1'b0;
    wp_d    = 1'b0;
    mem_we  = 1'b0;
    rdata_d = rdata_q;
    if (state_q == S_READY) begin
      ready_d = 1'b1;
      if (op_wr_q) begin
        if (wp_hit) begin
          wp_d = 1'b1;
        end else begin
          mem_we = 1'b1;
        end
      end else begin
        rdata_d = mem[idx];
      end
    end
  end

  assign mem_ready    = ready_q;
  assign mem_rdata    = rdata_q;
  assign wp_violation = wp_q;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT, default parameters.
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic        rd, wr, cs, ready, wp;

  sram_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata),
    .mem_read(rd), .mem_write(wr), .mem_cs(cs), .mem_ready(ready), .wp_violation(wp)
  );

  // Zero-wait-state DUT.
  logic [15:0] c0_addr;
  logic [7:0]  c0_wdata, c0_rdata;
  logic        c0_rd, c0_wr, c0_cs, c0_ready, c0_wp;

  sram_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(c0_addr), .mem_wdata(c0_wdata), .mem_rdata(c0_rdata),
    .mem_read(c0_rd), .mem_write(c0_wr), .mem_cs(c0_cs), .mem_ready(c0_ready), .wp_violation(c0_wp)
  );

`ifdef SRAM_RESPONDER_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef struct {
    bit         is_rd;
    logic [7:0] rdv;
    logic       wpv;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every mem_ready pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wp && !ready) chk("wp_without_ready", 1, 0);
      if (ready) begin
        ready_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("ready_latency", cyc, e.cyc);
          if (e.is_rd) chk("rdata", rdata, e.rdv);
          chk("wp_violation", wp, e.wpv);
        end
      end
    end
  end

  task automatic do_access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd, input logic exp_wp);
    exp_t e;
    bit got;
    @(negedge clk);
    cs = 1; rd = !is_wr; wr = is_wr; addr = a; wdata = d;
    e.is_rd = !is_wr; e.rdv = exp_rd; e.wpv = exp_wp; e.cyc = cyc + 1 + WS + 1;
    sbq.push_back(e);
    @(negedge clk);
    // Disturb inputs after sampling; the access must use the latched values.
    rd = 0; wr = 0; addr = ~a; wdata = ~d;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ready) got = 1;
      else @(negedge clk);
    end
    if (!got) chk("ready_timeout", 0, 1);
    cs = 0;
    @(negedge clk);
  endtask

  task automatic c0_window(input int n, output int pulses, output int first_cyc, output logic [7:0] rdv);
    pulses = 0; first_cyc = -1; rdv = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (c0_ready) begin
        if (pulses == 0) begin
          first_cyc = cyc;
          rdv = c0_rdata;
        end
        pulses++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, n0, p, fc;
    logic [7:0] rv;

    rst = 1; cs = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
    c0_cs = 0; c0_rd = 0; c0_wr = 0; c0_addr = 0; c0_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_wp", wp, 0);
    rst = 0;
    @(negedge clk);

    // Basic write then back-to-back read.
    do_access(1, 16'h0010, 8'hA5, 8'h00, 0);
    do_access(0, 16'h0010, 8'h00, 8'hA5, 0);

    // Aliasing at default ADDR_BITS.
    do_access(1, 16'h0FFF, 8'h3C, 8'h00, 0);
    do_access(0, 16'h1FFF, 8'h00, 8'h3C, 0);
    do_access(1, 16'h1000, 8'hC3, 8'h00, 0);
    do_access(0, 16'h0000, 8'h00, 8'hC3, 0);

    // Aborted write leaves prior contents and produces no handshake.
    do_access(1, 16'h0020, 8'h55, 8'h00, 0);
    @(negedge clk);
    cs = 1; wr = 1; addr = 16'h0020; wdata = 8'h11;
    @(negedge clk);
    cs = 0; wr = 0;
    k = ready_cnt;
    repeat (6) @(negedge clk);
    chk("abort_no_ready", ready_cnt, k);
    do_access(0, 16'h0020, 8'h00, 8'h55, 0);

    // Write protection region (alias 0x0200 preloaded with 0x00).
    do_access(1, 16'h0200, 8'h00, 8'h00, 0);
    do_access(1, 16'hF200, 8'h77, 8'h00, WP_ON);
    do_access(0, 16'hF200, 8'h00, WP_ON ? 8'h00 : 8'h77, 0);
    do_access(0, 16'h0200, 8'h00, WP_ON ? 8'h00 : 8'h77, 0);

    // Reset in READY of a write cancels the commit.
    do_access(1, 16'h0030, 8'h00, 8'h00, 0);
    do_access(0, 16'h0010, 8'h00, 8'hA5, 0);
    @(negedge clk);
    cs = 1; wr = 1; addr = 16'h0030; wdata = 8'hEE;
    @(negedge clk);
    wr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_ready_ready", ready, 0);
    chk("rst_ready_rdata", rdata, 8'h00);
    chk("rst_ready_wp", wp, 0);
    rst = 0; cs = 0;
    @(negedge clk);
    do_access(0, 16'h0030, 8'h00, 8'h00, 0);

    // Zero wait states: one pulse per cs assertion, on the next edge.
    @(negedge clk);
    c0_cs = 1; c0_wr = 1; c0_addr = 16'h0040; c0_wdata = 8'h5A; n0 = cyc;
    c0_window(4, p, fc, rv);
    chk("ws0_write_pulses", p, 1);
    chk("ws0_write_latency", fc, n0 + 2);
    c0_cs = 0; c0_wr = 0;
    @(negedge clk);
    c0_cs = 1; c0_rd = 1; c0_addr = 16'h0040; n0 = cyc;
    c0_window(5, p, fc, rv);
    chk("ws0_read_pulses", p, 1);
    chk("ws0_read_latency", fc, n0 + 2);
    chk("ws0_read_data", rv, 8'h5A);
    c0_cs = 0;
    @(negedge clk);
    c0_cs = 1; n0 = cyc;
    c0_window(3, p, fc, rv);
    chk("ws0_rereq_pulses", p, 1);
    chk("ws0_rereq_latency", fc, n0 + 2);
    chk("ws0_rereq_data", rv, 8'h5A);
    c0_cs = 0; c0_rd = 0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
